// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported byte memory with a two-cycle read latency.
// Round-robin on ties, optional ownership lock, one transaction in flight at a time.
module mem_arbiter #(
  parameter int unsigned addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req_i,
  input  logic                  b_req_i,
  input  logic                  a_we_i,
  input  logic                  b_we_i,
  input  logic [addr_width-1:0] a_addr_i,
  input  logic [addr_width-1:0] b_addr_i,
  input  logic [7:0]            a_wdata_i,
  input  logic [7:0]            b_wdata_i,
  input  logic                  a_lock_i,
  input  logic                  b_lock_i,
  output logic                  a_gnt_o,
  output logic                  b_gnt_o,
  output logic                  a_done_o,
  output logic                  b_done_o,
  output logic [7:0]            a_rdata_o,
  output logic [7:0]            b_rdata_o,
  output logic [addr_width-1:0] mem_raddr_o,
  output logic [addr_width-1:0] mem_waddr_o,
  output logic [7:0]            mem_data_in_o,
  output logic                  mem_write_o,
  input  logic [7:0]            mem_data_out_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2, StRd3} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;  // 1 = port B owns the transaction
  logic                  last_q, last_d;    // 1 = port B won the last grant
  logic                  lock_q, lock_d;
  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                  a_done_q, a_done_d, b_done_q, b_done_d;
  logic                  mem_write_q, mem_write_d;
  logic [7:0]            a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [addr_width-1:0] raddr_q, raddr_d, waddr_q, waddr_d;

  logic                  lock_hold, a_ok, b_ok, pick_b, sel_we, owner_lock;
  logic [addr_width-1:0] sel_addr;
  logic [7:0]            sel_wdata;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lock_d      = lock_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    mem_write_d = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;

    owner_lock = owner_q ? b_lock_i : a_lock_i;
    // A lock only keeps blocking the other port while the owner still asserts it.
    lock_hold  = lock_q & owner_lock;
    a_ok       = a_req_i & ~(lock_hold & owner_q);
    b_ok       = b_req_i & ~(lock_hold & ~owner_q);
    pick_b     = b_ok & (~a_ok | ~last_q);
    sel_we     = pick_b ? b_we_i : a_we_i;
    sel_addr   = pick_b ? b_addr_i : a_addr_i;
    sel_wdata  = pick_b ? b_wdata_i : a_wdata_i;

    unique case (state_q)
      StIdle: begin
        if (a_ok || b_ok) begin
          owner_d = pick_b;
          last_d  = pick_b;
          a_gnt_d = ~pick_b;
          b_gnt_d = pick_b;
          if (sel_we) begin
            waddr_d     = sel_addr;
            wdata_d     = sel_wdata;
            mem_write_d = 1'b1;
            state_d     = StWr;
          end else begin
            raddr_d = sel_addr;
            state_d = StRd1;
          end
        end
      end
      StWr: begin
        a_done_d = ~owner_q;
        b_done_d = owner_q;
        lock_d   = owner_lock;
        state_d  = StIdle;
      end
      StRd1: state_d = StRd2;
      StRd2: state_d = StRd3;
      StRd3: begin
        if (owner_q) b_rdata_d = mem_data_out_i;
        else         a_rdata_d = mem_data_out_i;
        a_done_d = ~owner_q;
        b_done_d = owner_q;
        lock_d   = owner_lock;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;  // pretend B won last so A takes the first tie
      lock_q      <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      mem_write_q <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      mem_write_q <= mem_write_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
    end
  end

  assign a_gnt_o       = a_gnt_q;
  assign b_gnt_o       = b_gnt_q;
  assign a_done_o      = a_done_q;
  assign b_done_o      = b_done_q;
  assign a_rdata_o     = a_rdata_q;
  assign b_rdata_o     = b_rdata_q;
  assign mem_raddr_o   = raddr_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_data_in_o = wdata_q;
  assign mem_write_o   = mem_write_q;
  assign busy_o        = (state_q != StIdle);

endmodule
